// File: rtl/bless_port_alloc_pkg.sv
// -----------------------------------------------------------------------------
// bless_port_alloc_pkg
// Shared constants and types for the BLESS router port-allocation stage.
//   - Port count and index constants (N, E, S, W, local).
//   - Flit field positions: valid | age | dst_x | dst_y | src_id | payload.
//   - Flit and port-preference-vector types.
//   - lowest_free_net(): one-hot of the lowest free network port (0..3).
// -----------------------------------------------------------------------------
package bless_port_alloc_pkg;

    localparam int NUM_PORT     = 5;
    localparam int LOG_NUM_PORT = 3;
    localparam int DATA_WIDTH   = 64;
    localparam int AGE_W        = 8;
    localparam int COORD_W      = 3;
    localparam int SRC_ID_W     = 5;

    // Field positions, packed downward from the MSB.
    localparam int VALID_BIT  = DATA_WIDTH - 1;
    localparam int AGE_MSB    = VALID_BIT - 1;
    localparam int AGE_LSB    = VALID_BIT - AGE_W;
    localparam int DST_X_MSB  = AGE_LSB - 1;
    localparam int DST_X_LSB  = AGE_LSB - COORD_W;
    localparam int DST_Y_MSB  = DST_X_LSB - 1;
    localparam int DST_Y_LSB  = DST_X_LSB - COORD_W;
    localparam int SRC_ID_MSB = DST_Y_LSB - 1;
    localparam int SRC_ID_LSB = DST_Y_LSB - SRC_ID_W;

    // Port indices; PORT_L is injection on input, ejection on output.
    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef logic [DATA_WIDTH-1:0] flit_t;
    typedef logic [NUM_PORT-1:0]   ppv_t;

    // Deflection target: lowest-index free network port. Local is never
    // offered because a deflected flit must stay in the network.
    function automatic ppv_t lowest_free_net(input logic [3:0] free);
        ppv_t grant;
        grant = '0;
        for (int p = 3; p >= 0; p--) begin
            if (free[p]) begin
                grant    = '0;
                grant[p] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/bless_port_alloc_if.sv
// -----------------------------------------------------------------------------
// bless_port_alloc_if
// Flit bus between the router input links, the allocation stage and the
// crossbar.
//   in_0..in_4      : incoming flits (N, E, S, W, local inject)
//   inject_ready    : local injection may present a flit this cycle
//   flit_0..flit_4  : registered flits towards the crossbar
//   ppv_0..ppv_4    : one-hot output-port grant aligned with each flit
// master modport = upstream/crossbar side, slave modport = allocation stage.
// -----------------------------------------------------------------------------
interface bless_port_alloc_if;
    import bless_port_alloc_pkg::*;

    flit_t in_0;
    flit_t in_1;
    flit_t in_2;
    flit_t in_3;
    flit_t in_4;
    logic  inject_ready;
    flit_t flit_0;
    flit_t flit_1;
    flit_t flit_2;
    flit_t flit_3;
    flit_t flit_4;
    ppv_t  ppv_0;
    ppv_t  ppv_1;
    ppv_t  ppv_2;
    ppv_t  ppv_3;
    ppv_t  ppv_4;

    modport master (
        output in_0, in_1, in_2, in_3, in_4,
        input  inject_ready,
        input  flit_0, flit_1, flit_2, flit_3, flit_4,
        input  ppv_0, ppv_1, ppv_2, ppv_3, ppv_4
    );

    modport slave (
        input  in_0, in_1, in_2, in_3, in_4,
        output inject_ready,
        output flit_0, flit_1, flit_2, flit_3, flit_4,
        output ppv_0, ppv_1, ppv_2, ppv_3, ppv_4
    );

endinterface

// File: rtl/bless_port_alloc_xy_route.sv
// -----------------------------------------------------------------------------
// bless_port_alloc_xy_route
// Combinational XY (dimension-ordered) routing: X is resolved first, then Y,
// and a flit already at this router goes to the local port.
//   i_dst_x, i_dst_y : destination coordinates of the flit
//   o_ppv            : one-hot productive output port
// -----------------------------------------------------------------------------
module bless_port_alloc_xy_route
    import bless_port_alloc_pkg::*;
#(
    parameter int LOC_X = 0,
    parameter int LOC_Y = 0
)(
    input  logic [COORD_W-1:0] i_dst_x,
    input  logic [COORD_W-1:0] i_dst_y,
    output ppv_t               o_ppv
);

    localparam logic [COORD_W-1:0] LX = COORD_W'(LOC_X);
    localparam logic [COORD_W-1:0] LY = COORD_W'(LOC_Y);

    // Differences with one guard bit: the guard bit set means dst < loc.
    // This keeps the comparison well-formed even when LOC is zero.
    logic [COORD_W:0] w_dx;
    logic [COORD_W:0] w_dy;

    assign w_dx = {1'b0, i_dst_x} - {1'b0, LX};
    assign w_dy = {1'b0, i_dst_y} - {1'b0, LY};

    always_comb begin
        o_ppv = '0;
        if (w_dx != '0) begin
            if (w_dx[COORD_W]) o_ppv[PORT_W] = 1'b1;
            else               o_ppv[PORT_E] = 1'b1;
        end else if (w_dy != '0) begin
            if (w_dy[COORD_W]) o_ppv[PORT_N] = 1'b1;
            else               o_ppv[PORT_S] = 1'b1;
        end else begin
            o_ppv[PORT_L] = 1'b1;
        end
    end

endmodule

// File: rtl/bless_port_alloc.sv
// -----------------------------------------------------------------------------
// bless_port_alloc
// Allocation stage in front of the 5-port crossbar of a bufferless deflection
// router. Incoming flits are registered with age+1 (saturating); from that
// register the stage computes XY productive ports, ranks flits oldest-first
// (ties to lower input index) and grants output ports greedily. Losers are
// deflected to the lowest free network port; only one flit may eject.
//   clk, reset : clock, synchronous active-high reset
//   port       : bless_port_alloc_if.slave (in_*, inject_ready, flit_*, ppv_*)
// Optional build macro GOLDEN_FLIT_EN: a rotating golden source ID whose flits
// outrank every other flit, advancing once every EPOCH_LEN cycles.
// -----------------------------------------------------------------------------
module bless_port_alloc
    import bless_port_alloc_pkg::*;
#(
    parameter int LOC_X     = 0,
    parameter int LOC_Y     = 0,
    parameter int EPOCH_LEN = 64
)(
    input  logic               clk,
    input  logic               reset,
    bless_port_alloc_if.slave  port
);

    flit_t               w_in    [NUM_PORT];
    flit_t               w_cap   [NUM_PORT];
    flit_t               r_flit  [NUM_PORT];
    logic [NUM_PORT-1:0] w_valid;
    logic [NUM_PORT-1:0] w_golden;
    logic [AGE_W:0]      w_key   [NUM_PORT];
    logic [LOG_NUM_PORT-1:0] w_rank [NUM_PORT];
    ppv_t                w_prod  [NUM_PORT];
    ppv_t                w_ppv   [NUM_PORT];
    logic                w_inject_ready;

    assign w_in[0] = port.in_0;
    assign w_in[1] = port.in_1;
    assign w_in[2] = port.in_2;
    assign w_in[3] = port.in_3;
    assign w_in[4] = port.in_4;

    // Four network outputs exist for non-ejecting flits, so injection is only
    // allowed when at least one network input is idle this cycle.
    assign w_inject_ready = ~&{w_in[PORT_N][VALID_BIT], w_in[PORT_E][VALID_BIT],
                               w_in[PORT_S][VALID_BIT], w_in[PORT_W][VALID_BIT]};
    assign port.inject_ready = w_inject_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORT; gi++) begin : g_port
            logic             w_accept;
            logic [AGE_W-1:0] w_age;
            logic [AGE_W-1:0] w_age_inc;

            if (gi == PORT_L) begin : g_inject
                // An injection offered without inject_ready is dropped.
                assign w_accept = w_in[gi][VALID_BIT] & w_inject_ready;
            end else begin : g_network
                assign w_accept = w_in[gi][VALID_BIT];
            end

            assign w_age     = w_in[gi][AGE_MSB:AGE_LSB];
            assign w_age_inc = (&w_age) ? w_age : w_age + 1'b1;
            // Invalid flits are stored as all zeros so stale fields never
            // reach the crossbar.
            assign w_cap[gi] = w_accept ? {1'b1, w_age_inc, w_in[gi][AGE_LSB-1:0]} : '0;

            assign w_valid[gi] = r_flit[gi][VALID_BIT];
            // Golden status sits above the age so it dominates the comparison.
            assign w_key[gi]   = {w_golden[gi], r_flit[gi][AGE_MSB:AGE_LSB]};

            bless_port_alloc_xy_route #(
                .LOC_X (LOC_X),
                .LOC_Y (LOC_Y)
            ) u_xy_route (
                .i_dst_x (r_flit[gi][DST_X_MSB:DST_X_LSB]),
                .i_dst_y (r_flit[gi][DST_Y_MSB:DST_Y_LSB]),
                .o_ppv   (w_prod[gi])
            );
        end
    endgenerate

    // Stage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_PORT; k++) r_flit[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_PORT; k++) r_flit[k] <= w_cap[k];
        end
    end

`ifdef GOLDEN_FLIT_EN
    localparam int EPOCH_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

    logic [EPOCH_W-1:0]  r_epoch_cnt;
    logic [SRC_ID_W-1:0] r_golden_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_epoch_cnt <= '0;
            r_golden_id <= '0;
        end else if (r_epoch_cnt == EPOCH_W'(EPOCH_LEN - 1)) begin
            r_epoch_cnt <= '0;
            r_golden_id <= r_golden_id + 1'b1;   // wraps 31 -> 0 naturally
        end else begin
            r_epoch_cnt <= r_epoch_cnt + 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NUM_PORT; gi++) begin : g_golden
            assign w_golden[gi] = w_valid[gi] &&
                                  (r_flit[gi][SRC_ID_MSB:SRC_ID_LSB] == r_golden_id);
        end
    endgenerate
`else
    assign w_golden = '0;
`endif

    // Rank = number of valid flits that beat this one. Valid flits therefore
    // hold distinct ranks 0..n-1; ranks of invalid flits are never used.
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            w_rank[i] = '0;
            for (int j = 0; j < NUM_PORT; j++) begin
                if ((j != i) && w_valid[j] &&
                    ((w_key[j] > w_key[i]) || ((w_key[j] == w_key[i]) && (j < i)))) begin
                    w_rank[i] = w_rank[i] + 1'b1;
                end
            end
        end
    end

    // Greedy grant in rank order. With injection gated there are at most four
    // valid flits, so a free network port always exists for a deflection.
    always_comb begin
        ppv_t v_free;
        ppv_t v_grant;
        v_free  = '1;
        v_grant = '0;
        for (int k = 0; k < NUM_PORT; k++) w_ppv[k] = '0;
        for (int r = 0; r < NUM_PORT; r++) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                if (w_valid[i] && (w_rank[i] == LOG_NUM_PORT'(r))) begin
                    if ((w_prod[i] & v_free) != '0) v_grant = w_prod[i];
                    else                            v_grant = lowest_free_net(v_free[PORT_W:PORT_N]);
                    w_ppv[i] = v_grant;
                    v_free   = v_free & ~v_grant;
                end
            end
        end
    end

    // Injection without inject_ready is a protocol violation by the source.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_in[PORT_L][VALID_BIT] && !w_inject_ready));
        end
    end

    assign port.flit_0 = r_flit[0];
    assign port.flit_1 = r_flit[1];
    assign port.flit_2 = r_flit[2];
    assign port.flit_3 = r_flit[3];
    assign port.flit_4 = r_flit[4];
    assign port.ppv_0  = w_ppv[0];
    assign port.ppv_1  = w_ppv[1];
    assign port.ppv_2  = w_ppv[2];
    assign port.ppv_3  = w_ppv[3];
    assign port.ppv_4  = w_ppv[4];

endmodule

// File: tb/tb_bless_port_alloc.sv
// -----------------------------------------------------------------------------
// tb_bless_port_alloc
// Self-checking bench for bless_port_alloc. A reference model sorts the
// captured flits by (golden, age, lower index) and hands out ports greedily.
// Build with GOLDEN_FLIT_EN to exercise the golden-flit ranking (EPOCH_LEN=4).
// -----------------------------------------------------------------------------
module tb_bless_port_alloc;
    import bless_port_alloc_pkg::*;

    localparam int TB_LOC_X = 2;
    localparam int TB_LOC_Y = 2;
`ifdef GOLDEN_FLIT_EN
    localparam int TB_EPOCH = 4;
`else
    localparam int TB_EPOCH = 64;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bless_port_alloc_if bus();

    bless_port_alloc #(
        .LOC_X     (TB_LOC_X),
        .LOC_Y     (TB_LOC_Y),
        .EPOCH_LEN (TB_EPOCH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus)
    );

    logic [63:0] tb_in    [5];
    logic [63:0] exp_flit [5];
    logic [4:0]  exp_ppv  [5];
    logic [63:0] dut_flit [5];
    logic [4:0]  dut_ppv  [5];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign dut_flit[0] = bus.flit_0;
    assign dut_flit[1] = bus.flit_1;
    assign dut_flit[2] = bus.flit_2;
    assign dut_flit[3] = bus.flit_3;
    assign dut_flit[4] = bus.flit_4;
    assign dut_ppv[0]  = bus.ppv_0;
    assign dut_ppv[1]  = bus.ppv_1;
    assign dut_ppv[2]  = bus.ppv_2;
    assign dut_ppv[3]  = bus.ppv_3;
    assign dut_ppv[4]  = bus.ppv_4;

    // Non-reset clock edges since the last reset: golden id = cyc/EPOCH mod 32.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [63:0] mk(input bit v, input int age, input int dx,
                                       input int dy, input int src);
        logic [63:0] f;
        logic [63:0] r;
        r = {$urandom, $urandom};
        f = {v, 8'(age), 3'(dx), 3'(dy), 5'(src), r[43:0]};
        return f;
    endfunction

    function automatic int productive(input logic [63:0] f);
        int dx;
        int dy;
        dx = int'(f[54:52]);
        dy = int'(f[51:49]);
        if (dx > TB_LOC_X) return 1;
        if (dx < TB_LOC_X) return 3;
        if (dy > TB_LOC_Y) return 2;
        if (dy < TB_LOC_Y) return 0;
        return 4;
    endfunction

    function automatic bit is_golden(input logic [63:0] f, input int gid);
`ifdef GOLDEN_FLIT_EN
        return int'(f[48:44]) == gid;
`else
        return (gid < 0) && f[63];
`endif
    endfunction

    task automatic compute_expected();
        bit all_net;
        bit used [5];
        bit done [5];
        int age;
        int best;
        int prod;
        int gid;
        bit ga;
        bit gb;
        all_net = tb_in[0][63] && tb_in[1][63] && tb_in[2][63] && tb_in[3][63];
        gid = (cyc / TB_EPOCH) % 32;
        for (int k = 0; k < 5; k++) begin
            used[k] = 1'b0;
            done[k] = 1'b0;
            exp_ppv[k] = '0;
            if (tb_in[k][63] && (k < 4 || !all_net)) begin
                age = int'(tb_in[k][62:55]);
                if (age < 255) age = age + 1;
                exp_flit[k] = {1'b1, 8'(age), tb_in[k][54:0]};
            end else begin
                exp_flit[k] = '0;
            end
        end
        // Repeatedly pick the best remaining flit and give it a port.
        repeat (5) begin
            best = -1;
            for (int i = 0; i < 5; i++) begin
                if (exp_flit[i][63] && !done[i]) begin
                    if (best < 0) begin
                        best = i;
                    end else begin
                        ga = is_golden(exp_flit[i], gid);
                        gb = is_golden(exp_flit[best], gid);
                        if (ga != gb) begin
                            if (ga) best = i;
                        end else if (exp_flit[i][62:55] > exp_flit[best][62:55]) begin
                            best = i;
                        end
                    end
                end
            end
            if (best >= 0) begin
                done[best] = 1'b1;
                prod = productive(exp_flit[best]);
                if (used[prod]) begin
                    prod = -1;
                    for (int p = 0; p < 4; p++) if (!used[p] && prod < 0) prod = p;
                end
                if (prod >= 0) begin
                    used[prod] = 1'b1;
                    exp_ppv[best] = 5'(1 << prod);
                end
            end
        end
    endtask

    task automatic drive();
        bus.in_0 = tb_in[0];
        bus.in_1 = tb_in[1];
        bus.in_2 = tb_in[2];
        bus.in_3 = tb_in[3];
        bus.in_4 = tb_in[4];
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 5; k++) tb_in[k] = '0;
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compute_expected();
        $display("txn t=%0t cyc=%0d in_v=%b%b%b%b%b ppv=%b %b %b %b %b", $time, cyc,
                 tb_in[4][63], tb_in[3][63], tb_in[2][63], tb_in[1][63], tb_in[0][63],
                 dut_ppv[0], dut_ppv[1], dut_ppv[2], dut_ppv[3], dut_ppv[4]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tb_in[k] = mk(1, 7, 3, 2, 31);
        tb_in[4] = '0;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        #1;
        for (int k = 0; k < 5; k++) begin
            total++; if (dut_flit[k] !== 64'd0) begin bad++; $display("FAIL reset flit_%0d got=%h exp=0", k, dut_flit[k]); end
            total++; if (dut_ppv[k] !== 5'd0) begin bad++; $display("FAIL reset ppv_%0d got=%b exp=00000", k, dut_ppv[k]); end
        end
        total++; if (bus.inject_ready !== 1'b1) begin bad++; $display("FAIL reset inject_ready got=%b exp=1", bus.inject_ready); end
        // A flit in the stage register is discarded by reset.
        tb_in[1] = mk(1, 10, 3, 2, 31);
        drive();
        tick();
        total++; if (dut_ppv[1] !== 5'b00010) begin bad++; $display("FAIL preflush ppv_1 got=%b exp=00010", dut_ppv[1]); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            total++; if (dut_flit[k] !== 64'd0 || dut_ppv[k] !== 5'd0) begin bad++; $display("FAIL flush port_%0d got=%h/%b exp=0/00000", k, dut_flit[k], dut_ppv[k]); end
        end
    endtask

    task automatic test_single_east();
        clear_inputs();
        tb_in[0] = mk(1, 3, TB_LOC_X + 1, TB_LOC_Y, 31);
        drive();
        tick();
        total++; if (dut_flit[0][62:55] !== 8'd4) begin bad++; $display("FAIL single age got=%0d exp=4", dut_flit[0][62:55]); end
        total++; if (dut_ppv[0] !== 5'b00010) begin bad++; $display("FAIL single ppv_0 got=%b exp=00010", dut_ppv[0]); end
        for (int k = 0; k < 5; k++) begin
            total++; if (dut_flit[k] !== exp_flit[k]) begin bad++; $display("FAIL single flit_%0d got=%h exp=%h", k, dut_flit[k], exp_flit[k]); end
            total++; if (dut_ppv[k] !== exp_ppv[k]) begin bad++; $display("FAIL single ppv_%0d got=%b exp=%b", k, dut_ppv[k], exp_ppv[k]); end
        end
    endtask

    task automatic test_conflict();
        clear_inputs();
        tb_in[1] = mk(1, 9, 3, 2, 31);
        tb_in[3] = mk(1, 2, 3, 2, 31);
        drive();
        tick();
        total++; if (dut_ppv[1] !== 5'b00010) begin bad++; $display("FAIL conflict ppv_1 got=%b exp=00010", dut_ppv[1]); end
        total++; if (dut_ppv[3] !== 5'b00001) begin bad++; $display("FAIL conflict ppv_3 got=%b exp=00001", dut_ppv[3]); end
        for (int k = 0; k < 5; k++) begin
            total++; if (dut_ppv[k] !== exp_ppv[k]) begin bad++; $display("FAIL conflict ppv_%0d got=%b exp=%b", k, dut_ppv[k], exp_ppv[k]); end
        end
    endtask

    task automatic test_all_network();
        logic [4:0] all_or;
        clear_inputs();
        tb_in[0] = mk(1, 1, 3, 2, 31);
        tb_in[1] = mk(1, 2, 3, 2, 31);
        tb_in[2] = mk(1, 3, 2, 0, 31);
        tb_in[3] = mk(1, 4, 0, 2, 31);
        drive();
        #1;
        total++; if (bus.inject_ready !== 1'b0) begin bad++; $display("FAIL allnet inject_ready got=%b exp=0", bus.inject_ready); end
        tick();
        all_or = dut_ppv[0] | dut_ppv[1] | dut_ppv[2] | dut_ppv[3];
        total++; if (all_or !== 5'b01111) begin bad++; $display("FAIL allnet union got=%b exp=01111", all_or); end
        for (int k = 0; k < 4; k++) begin
            total++; if (!$onehot(dut_ppv[k])) begin bad++; $display("FAIL allnet onehot_%0d got=%b exp=onehot", k, dut_ppv[k]); end
            total++; if (dut_ppv[k] !== exp_ppv[k]) begin bad++; $display("FAIL allnet ppv_%0d got=%b exp=%b", k, dut_ppv[k], exp_ppv[k]); end
        end
    endtask

    task automatic test_two_eject();
        clear_inputs();
        tb_in[0] = mk(1, 5, TB_LOC_X, TB_LOC_Y, 31);
        tb_in[2] = mk(1, 7, TB_LOC_X, TB_LOC_Y, 31);
        drive();
        tick();
        total++; if (dut_ppv[2] !== 5'b10000) begin bad++; $display("FAIL eject ppv_2 got=%b exp=10000", dut_ppv[2]); end
        total++; if (dut_ppv[0] !== 5'b00001) begin bad++; $display("FAIL eject ppv_0 got=%b exp=00001", dut_ppv[0]); end
        for (int k = 0; k < 5; k++) begin
            total++; if (dut_flit[k] !== exp_flit[k]) begin bad++; $display("FAIL eject flit_%0d got=%h exp=%h", k, dut_flit[k], exp_flit[k]); end
        end
    endtask

    task automatic test_saturation_inject();
        clear_inputs();
        tb_in[1] = mk(1, 255, 3, 2, 31);
        tb_in[3] = mk(1, 254, 3, 2, 31);
        tb_in[4] = mk(1, 0, TB_LOC_X, TB_LOC_Y + 1, 31);
        drive();
        #1;
        total++; if (bus.inject_ready !== 1'b1) begin bad++; $display("FAIL sat inject_ready got=%b exp=1", bus.inject_ready); end
        tick();
        total++; if (dut_flit[3][62:55] !== 8'd255) begin bad++; $display("FAIL sat age_3 got=%0d exp=255", dut_flit[3][62:55]); end
        total++; if (dut_flit[1][62:55] !== 8'd255) begin bad++; $display("FAIL sat age_1 got=%0d exp=255", dut_flit[1][62:55]); end
        total++; if (dut_ppv[1] !== 5'b00010) begin bad++; $display("FAIL sat ppv_1 got=%b exp=00010", dut_ppv[1]); end
        total++; if (dut_ppv[3] !== 5'b00001) begin bad++; $display("FAIL sat ppv_3 got=%b exp=00001", dut_ppv[3]); end
        total++; if (dut_ppv[4] !== 5'b00100) begin bad++; $display("FAIL sat ppv_4 got=%b exp=00100", dut_ppv[4]); end
        for (int k = 0; k < 5; k++) begin
            total++; if (dut_flit[k] !== exp_flit[k]) begin bad++; $display("FAIL sat flit_%0d got=%h exp=%h", k, dut_flit[k], exp_flit[k]); end
        end
    endtask

`ifdef GOLDEN_FLIT_EN
    task automatic test_golden();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        // Fourth edge wraps the epoch: golden id becomes 1.
        tb_in[0] = mk(1, 200, 3, 2, 7);
        tb_in[3] = mk(1, 0, 3, 2, 1);
        drive();
        tick();
        total++; if (dut_ppv[3] !== 5'b00010) begin bad++; $display("FAIL golden ppv_3 got=%b exp=00010", dut_ppv[3]); end
        total++; if (dut_ppv[0] !== 5'b00001) begin bad++; $display("FAIL golden ppv_0 got=%b exp=00001", dut_ppv[0]); end
        clear_inputs();
        repeat (3) tick();
        // Golden id is now 2, so the age-based order returns.
        tb_in[0] = mk(1, 200, 3, 2, 7);
        tb_in[3] = mk(1, 0, 3, 2, 1);
        drive();
        tick();
        total++; if (dut_ppv[0] !== 5'b00010) begin bad++; $display("FAIL golden2 ppv_0 got=%b exp=00010", dut_ppv[0]); end
        total++; if (dut_ppv[3] !== 5'b00001) begin bad++; $display("FAIL golden2 ppv_3 got=%b exp=00001", dut_ppv[3]); end
    endtask
`endif

    task automatic test_random();
        bit all_net;
        int sel;
        int age;
        logic [63:0] r;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 5; k++) begin
                sel = int'($urandom_range(0, 9));
                age = sel == 0 ? 255 : (sel == 1 ? 254 : int'($urandom_range(0, 255)));
                if ($urandom_range(0, 9) < 7) begin
                    tb_in[k] = mk(1, age, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                                  int'($urandom_range(0, 31)));
                end else begin
                    r = {$urandom, $urandom};
                    r[63] = 1'b0;
                    tb_in[k] = r;
                end
            end
            all_net = tb_in[0][63] && tb_in[1][63] && tb_in[2][63] && tb_in[3][63];
            if (all_net) tb_in[4][63] = 1'b0;
            drive();
            #1;
            total++; if (bus.inject_ready !== !all_net) begin bad++; $display("FAIL random inject_ready n=%0d got=%b exp=%b", n, bus.inject_ready, !all_net); end
            tick();
            for (int k = 0; k < 5; k++) begin
                total++; if (dut_flit[k] !== exp_flit[k]) begin bad++; $display("FAIL random flit_%0d n=%0d got=%h exp=%h", k, n, dut_flit[k], exp_flit[k]); end
                total++; if (dut_ppv[k] !== exp_ppv[k]) begin bad++; $display("FAIL random ppv_%0d n=%0d got=%b exp=%b", k, n, dut_ppv[k], exp_ppv[k]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) tb_in[k] = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_east();
        test_conflict();
        test_all_network();
        test_two_eject();
        test_saturation_inject();
`ifdef GOLDEN_FLIT_EN
        test_golden();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bless_port_alloc.md
Name: bless_port_alloc

Overview:
Pipeline stage directly upstream of the 5-port crossbar in the bufferless deflection (BLESS) router. It registers the five incoming flits and increments their age. It computes each flit's productive direction with XY routing. It then runs oldest-first greedy port allocation and drives one-hot port preference vectors (ppv_0..ppv_4) plus the aligned flits into the crossbar.

Parameters:
NUM_PORT, 5, ports 0=N 1=E 2=S 3=W 4=local; the local port carries injection on input and ejection on output.
DATA_WIDTH, 64, full flit width.
AGE_W, 8, age field width.
COORD_W, 3, width of each X and Y coordinate.
LOC_X, 0, this router's X coordinate.
LOC_Y, 0, this router's Y coordinate.
EPOCH_LEN, 64, cycles per golden epoch (used only with the optional feature).

Ports:
clk  input  1  clock.
reset  input  1  synchronous active-high reset.
in_0..in_4  input  DATA_WIDTH each  flits arriving on N, E, S, W and local-inject.
inject_ready  output  1  local injection may present a flit this cycle.
flit_0..flit_4  output  DATA_WIDTH each  registered flits, aligned with their ppv; these drive the crossbar data inputs.
ppv_0..ppv_4  output  NUM_PORT each  one-hot output-port grant per registered flit; all zeros means no flit.

Behaviour:
- Flit layout:
  - bit [DATA_WIDTH-1] = valid.
  - Next AGE_W bits = age.
  - Then DST_X, DST_Y, SRC_ID (5 bits).
  - Remainder = payload.
- Latency: one cycle. Flits arriving at in_k in cycle t appear on flit_k with ppv_k in cycle t+1. Allocation is combinational from the stage register.
- Age at capture: valid flits are registered with age+1, saturating at all-ones. Invalid flits are registered as all zeros.
- Productive port, XY routing:
  - DST_X > LOC_X → E; DST_X < LOC_X → W.
  - Otherwise DST_Y > LOC_Y → S; DST_Y < LOC_Y → N.
  - Otherwise → local.
- Rank: valid flits are ordered by age descending. Ties go to the lower input index.
- Greedy grant in rank order:
  - Each flit takes its productive port if that port is free.
  - Only one flit can take local (ejection) per cycle.
  - A flit that loses its port is deflected to the lowest-index free port among 0..3. It never goes to local.
- Invalid flits get ppv=0. Every valid flit gets exactly one grant, and no two grants coincide.
- Capacity: at most 4 network outputs are available to non-ejecting flits, so injection is gated.
  - inject_ready = 1 when fewer than 4 of in_0..in_3 are valid this cycle (combinational).
  - in_4 valid while inject_ready=0 is a protocol violation. The block drops in_4 and asserts a simulation error.
- Boundary cases:
  - All 4 network inputs valid, none ejecting: all 4 network ports are granted and local is unused.
  - Two flits both destined local: the older one ejects and the other deflects.
  - Age saturation: saturated flits tie and are resolved by index.
- Reset: the stage register clears, so flit_k=0, ppv_k=0 and inject_ready=1 in the cycle after reset. Flits in flight when reset is asserted are discarded.

Optional Feature:
GOLDEN_FLIT_EN
- Defined:
  - A golden-epoch counter counts 0..EPOCH_LEN-1 and wraps.
  - A golden ID register (5 bits) increments when the counter wraps. It wraps 31→0.
  - A valid flit whose SRC_ID equals the golden ID outranks every non-golden flit regardless of age.
  - Both the counter and the golden ID reset to 0.
- Undefined: no counter and no golden register; ranking is by age only.

Decomposition:
- Shared package / global header:
  - NUM_PORT, LOG_NUM_PORT, DATA_WIDTH.
  - Flit field offsets and widths (VALID, AGE, DST_X, DST_Y, SRC_ID).
  - Port index constants PORT_N, PORT_E, PORT_S, PORT_W, PORT_L.
- One sub-module is natural: xy_route, a combinational DST/LOC to one-hot productive-port vector, instantiated 5 times.

Test Plan:
- Reset, then all inputs zero → cycle 1: ppv_0..4=0, flit_0..4=0, inject_ready=1.
- Single flit on in_0 (age 3) with DST_X=LOC_X+1 → next cycle flit_0 has age 4 and ppv_0=00010 (E).
- in_1 (age 9) and in_3 (age 2) both want E → ppv_1=E; ppv_3 = lowest free non-local port, N=00001.
- in_0..in_3 all valid → inject_ready=0; all four ppv are distinct one-hot with no local grant.
- Two flits destined local, ages 5 and 7 → the age-7 flit gets ppv=10000; the other gets a network port.
- With GOLDEN_FLIT_EN and EPOCH_LEN=4:
  - After 4 cycles the golden ID = 1.
  - A flit with SRC_ID=1 and age 0 beats a flit with age 200 for the same port.
